gng_mul_arbiter: RTL and testbench

- Shares one 16x18 signed, 2-cycle multiplier among N_REQ requesters in the Gaussian noise generator, e.g. per-channel noise scaling.
- Round-robin arbitration accepts at most one operand pair per cycle.
- A tag pipeline carries the grant alongside the multiplier, so each result returns to the requester that issued it.
- An output stage delivers both the full 34-bit product and a rounded, saturated 16-bit scaled value.

---
 rtl/gng_mul_pkg.sv | 33 +++
 rtl/gng_smul_16_18.sv | 28 ++
 rtl/gng_mul_arbiter.sv | 141 ++++++++++++++
 tb/tb_gng_mul_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gng_mul_pkg.sv
// Shared widths, latencies and saturation helpers for the shared noise-scaling multiplier.
package gng_mul_pkg;

   localparam int A_W     = 16;
   localparam int B_W     = 18;
   localparam int P_W     = 34;
   localparam int R_W     = P_W + 1;
   localparam int MUL_LAT = 2;
   localparam int OUT_LAT = 3;
   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef struct packed {
      logic [15:0] value;
      logic        sat;
   } scaled_t;

   // Clips a rounded, shifted product into the signed 16-bit output range.
   function automatic scaled_t saturate16(input logic signed [R_W-1:0] r);
      scaled_t s;
      s.value = r[15:0];
      s.sat   = 1'b0;
      if (r > R_W'(SAT_MAX)) begin
         s.value = 16'(SAT_MAX);
         s.sat   = 1'b1;
      end else if (r < R_W'(SAT_MIN)) begin
         s.value = 16'(SAT_MIN);
         s.sat   = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/gng_smul_16_18.sv
// Two-cycle signed 16x18 multiplier: registered operands, then registered product.
module gng_smul_16_18
   import gng_mul_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic signed [A_W-1:0] a_i,
   input  logic signed [B_W-1:0] b_i,
   output logic signed [P_W-1:0] p_o
);

   logic signed [A_W-1:0] a_q;
   logic signed [B_W-1:0] b_q;

   // Operand register stage followed by the product register stage.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         a_q <= '0;
         b_q <= '0;
         p_o <= '0;
      end else begin
         a_q <= a_i;
         b_q <= b_i;
         p_o <= P_W'(a_q) * P_W'(b_q);
      end
   end

endmodule

// File: rtl/gng_mul_arbiter.sv
// Round-robin sharing of one signed multiplier among N_REQ requesters, with a
// tag pipeline that routes each product (full and scaled) back to its issuer.
module gng_mul_arbiter
   import gng_mul_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int SHIFT = 17
)
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*A_W-1:0]   req_a,
   input  logic [N_REQ*B_W-1:0]   req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       res_valid,
   output logic [P_W-1:0]         res_prod,
   output logic [15:0]            res_scaled,
   output logic                   res_sat,
   output logic                   busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic signed [R_W-1:0] ROUND_BIAS = R_W'(1) <<< (SHIFT - 1);

   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [PTR_W-1:0]        grantIdx;
   logic [N_REQ-1:0]        grant;
   logic                    grantAny;

   logic signed [A_W-1:0]   mulA;
   logic signed [B_W-1:0]   mulB;
   logic signed [P_W-1:0]   mulP;

   logic                    tagValid1_q, tagValid2_q;
   logic [N_REQ-1:0]        tagId1_q, tagId2_q;

   logic [N_REQ-1:0]        resValid_q;
   logic [P_W-1:0]          resProd_q;
   logic [15:0]             resScaled_q;
   logic                    resSat_q;

   logic signed [R_W-1:0]   rounded;
   scaled_t                 scaled;

   // Rotating priority search starting at ptr; nobody is granted while in reset.
   always_comb begin
      int idx;
      grant    = '0;
      grantIdx = '0;
      grantAny = 1'b0;
      idx      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!grantAny && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grantIdx   = PTR_W'(idx);
            grantAny   = 1'b1;
         end
      end
      if (!rstn) begin
         grant    = '0;
         grantAny = 1'b0;
      end
   end

   // Winner's successor becomes highest priority; pointer holds when idle.
   always_comb begin
      ptr_d = ptr_q;
      if (grantAny) begin
         ptr_d = (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + PTR_W'(1);
      end
   end

   // Steer the winner's operands onto the multiplier, zeros when nobody wins.
   always_comb begin
      mulA = '0;
      mulB = '0;
      if (grantAny) begin
         mulA = req_a[int'(grantIdx)*A_W +: A_W];
         mulB = req_b[int'(grantIdx)*B_W +: B_W];
      end
   end

   assign req_ready = grant;

   gng_smul_16_18 uMul (
      .clk  (clk),
      .rstn (rstn),
      .a_i  (mulA),
      .b_i  (mulB),
      .p_o  (mulP)
   );

   // Priority pointer and the two tag stages that track the multiplier's stages.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q       <= '0;
         tagValid1_q <= 1'b0;
         tagValid2_q <= 1'b0;
         tagId1_q    <= '0;
         tagId2_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         tagValid1_q <= grantAny;
         tagId1_q    <= grant;
         tagValid2_q <= tagValid1_q;
         tagId2_q    <= tagId1_q;
      end
   end

   // Round half up at the chosen shift, then clip to 16 bits.
   always_comb begin
      rounded = (R_W'(mulP) + ROUND_BIAS) >>> SHIFT;
      scaled  = saturate16(rounded);
   end

   // Output stage: strobe the owner for one cycle, data holds between results.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         resValid_q  <= '0;
         resProd_q   <= '0;
         resScaled_q <= '0;
         resSat_q    <= 1'b0;
      end else begin
         resValid_q <= tagValid2_q ? tagId2_q : '0;
         if (tagValid2_q) begin
            resProd_q   <= mulP;
            resScaled_q <= scaled.value;
            resSat_q    <= scaled.sat;
         end
      end
   end

   assign res_valid  = resValid_q;
   assign res_prod   = resProd_q;
   assign res_scaled = resScaled_q;
   assign res_sat    = resSat_q;
   assign busy       = tagValid1_q | tagValid2_q | (|resValid_q);

endmodule

// File: tb/tb_gng_mul_arbiter.sv
// Bench for the shared multiplier arbiter: scoreboard model plus directed literal cases.
module tb_gng_mul_arbiter;
   import gng_mul_pkg::*;

   localparam int N     = 4;
   localparam int SHIFT = 17;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*16-1:0]   req_a = '0;
   logic [N*18-1:0]   req_b = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      res_valid;
   logic [33:0]       res_prod;
   logic [15:0]       res_scaled;
   logic              res_sat;
   logic              busy;

   gng_mul_arbiter #(.N_REQ(N), .SHIFT(SHIFT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .res_valid  (res_valid),
      .res_prod   (res_prod),
      .res_scaled (res_scaled),
      .res_sat    (res_sat),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference scaling: floor((p + 2^(SHIFT-1)) / 2^SHIFT), then clip.
   function automatic void scaleRef(input longint p, output longint s, output longint sat);
      longint r;
      longint den;
      den = longint'(1) << SHIFT;
      r = p + (den / 2);
      if (r >= 0) r = r / den;
      else        r = -((-r + den - 1) / den);
      if (r > 32767)       begin s = 32767;  sat = 1; end
      else if (r < -32768) begin s = -32768; sat = 1; end
      else                 begin s = r;      sat = 0; end
   endfunction

   typedef struct {
      int           due;
      logic [N-1:0] id;
      longint       prod;
   } exp_t;

   exp_t         q[$];
   int           mPtr = 0;
   bit           checking = 0;
   longint       lastProd = 0, lastScaled = 0, lastSat = 0;
   logic [N-1:0] expValid, expReady;
   bit           popped;
   exp_t         e;

   // Scoreboard: every cycle compare outputs to the model, then advance the model.
   always @(negedge clk) begin
      expValid = '0;
      popped   = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         expValid = e.id;
         popped   = 1;
         lastProd = e.prod;
         scaleRef(e.prod, lastScaled, lastSat);
      end
      expReady = '0;
      if (rstn) begin
         for (int k = 0; k < N; k++) begin
            if (expReady == '0 && req_valid[(mPtr + k) % N]) expReady[(mPtr + k) % N] = 1'b1;
         end
      end
      if (checking) begin
         checkOutput("req_ready", req_ready, expReady);
         checkOutput("res_valid", res_valid, expValid);
         checkOutput("res_prod", $signed(res_prod), lastProd);
         checkOutput("res_scaled", $signed(res_scaled), lastScaled);
         checkOutput("res_sat", res_sat, lastSat);
         checkOutput("busy", busy, (popped || q.size() > 0) ? 1 : 0);
      end
      if (!rstn) begin
         q.delete();
         mPtr       = 0;
         lastProd   = 0;
         lastScaled = 0;
         lastSat    = 0;
         checking   = 1;
      end else begin
         for (int j = 0; j < N; j++) begin
            if (expReady[j] && req_valid[j]) begin
               e.due  = cyc + OUT_LAT;
               e.id   = expReady;
               e.prod = longint'($signed(req_a[16*j +: 16])) * longint'($signed(req_b[18*j +: 18]));
               q.push_back(e);
               mPtr = (j + 1) % N;
            end
         end
      end
   end

   // One operand pair on one requester, then literal checks at the fixed latency.
   task automatic applyStimulus(input int id, input int a, input int b,
                                input longint expProd, input longint expScaled, input longint expSat);
      bit got;
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[16*id +: 16] = 16'(a);
      req_b[18*id +: 18] = 18'(b);
      got = 0;
      for (int w = 0; w < 20 && !got; w++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      checkOutput("grant_seen", got, 1);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (OUT_LAT) @(negedge clk);
      checkOutput("lit_res_valid", res_valid, longint'(1) << id);
      checkOutput("lit_res_prod", $signed(res_prod), expProd);
      checkOutput("lit_res_scaled", $signed(res_scaled), expScaled);
      checkOutput("lit_res_sat", res_sat, expSat);
   endtask

   function automatic int randA();
      case ($urandom_range(0, 7))
         0:       return -32768;
         1:       return 32767;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   function automatic int randB();
      case ($urandom_range(0, 7))
         0:       return -131072;
         1:       return 131071;
         default: return int'($signed(18'($urandom)));
      endcase
   endfunction

   logic [N-1:0] hs;

   initial begin
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      applyStimulus(1, 100, -3, -300, 0, 0);
      applyStimulus(0, -32768, -131072, 64'sd4294967296, 32767, 1);
      applyStimulus(0, 32767, -131072, -64'sd4294836224, -32767, 0);
      applyStimulus(2, 1, 65536, 65536, 1, 0);
      applyStimulus(3, 1, 65535, 65535, 0, 0);
      applyStimulus(1, -1, 65536, -65536, 0, 0);

      // Pointer follows the last winner: 2 wins, then 3 beats 0, then 0.
      @(posedge clk); #1 req_valid = 4'b0100;
      @(negedge clk); checkOutput("ptr_grant_r2", req_ready, 4'b0100);
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk); checkOutput("ptr_grant_r3", req_ready, 4'b1000);
      @(posedge clk); #1 req_valid = 4'b0001;
      @(negedge clk); checkOutput("ptr_grant_r0", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      repeat (5) @(posedge clk);

      // Two ops in flight, then reset: neither may ever return.
      #1 req_valid = 4'b0001; req_a[15:0] = 16'd7; req_b[17:0] = 18'd9;
      @(negedge clk);
      @(posedge clk); #1 req_valid = 4'b0010; req_a[31:16] = 16'd5; req_b[35:18] = 18'd11;
      @(negedge clk);
      @(posedge clk); #1 req_valid = '0; rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_prod", $signed(res_prod), 0);
      checkOutput("rst_scaled", $signed(res_scaled), 0);
      checkOutput("rst_sat", res_sat, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("rst_no_valid", res_valid, 0);
      end

      // All four requesting continuously from ptr=0: strict rotation, gapless results.
      @(posedge clk); #1;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         req_a[16*i +: 16] = 16'(1000 * (i + 1));
         req_b[18*i +: 18] = 18'(-(i + 3));
      end
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k < 8) checkOutput("rr_ready", req_ready, longint'(1) << (k % N));
         if (k >= 3) checkOutput("rr_res_valid", res_valid, longint'(1) << ((k - 3) % N));
         if (k == 7) begin
            @(posedge clk); #1 req_valid = '0;
         end
      end

      // Randomised traffic; operands only change after their handshake.
      hs = '0;
      for (int it = 0; it < 400; it++) begin
         @(posedge clk); #1;
         rstn = (it == 200) ? 1'b0 : 1'b1;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || hs[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_a[16*i +: 16] = 16'(randA());
               req_b[18*i +: 18] = 18'(randB());
            end
         end
         @(negedge clk);
         hs = req_valid & req_ready;
      end
      @(posedge clk); #1 req_valid = '0; rstn = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
